// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - shares one memory port between the i-cache and d-cache miss paths
// One transaction at a time, round-robin on simultaneous requests, one turnaround cycle after each.
module cache_mem_arbiter #(
  parameter int A_WIDTH = 32,
  parameter bit D_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic [A_WIDTH-1:0] i_a,
  input  logic               i_strobe,
  output logic [31:0]        i_dout,
  output logic               i_ready,
  input  logic [A_WIDTH-1:0] d_a,
  input  logic [31:0]        d_din,
  input  logic               d_we,
  input  logic               d_strobe,
  output logic [31:0]        d_dout,
  output logic               d_ready,
  output logic [A_WIDTH-1:0] m_a,
  output logic [31:0]        m_din,
  output logic               m_we,
  output logic               m_strobe,
  input  logic [31:0]        m_dout,
  input  logic               m_ready
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, DONE} state_t;

  state_t             state, state_nxt;
  logic               last_d, last_d_nxt;
  logic               grant_d;
  logic [A_WIDTH-1:0] a_nxt;
  logic [31:0]        din_nxt;
  logic               we_nxt;

  // last_d = 1 means the data side won the most recent tie
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state  <= IDLE;
      last_d <= ~D_FIRST;
      m_a    <= '0;
      m_din  <= '0;
      m_we   <= 1'b0;
    end else begin
      state  <= state_nxt;
      last_d <= last_d_nxt;
      m_a    <= a_nxt;
      m_din  <= din_nxt;
      m_we   <= we_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    last_d_nxt = last_d;
    a_nxt      = m_a;
    din_nxt    = m_din;
    we_nxt     = m_we;
    grant_d    = 1'b0;
    m_strobe   = 1'b0;
    i_ready    = 1'b0;
    d_ready    = 1'b0;
    case (state)
      IDLE: begin
        if (i_strobe || d_strobe) begin
          grant_d = d_strobe & (~i_strobe | ~last_d);
          if (i_strobe && d_strobe) last_d_nxt = grant_d;
          if (grant_d) begin
            a_nxt     = d_a;
            din_nxt   = d_din;
            we_nxt    = d_we;
            state_nxt = GNT_D;
          end else begin
            a_nxt     = i_a;
            din_nxt   = 32'd0;
            we_nxt    = 1'b0;
            state_nxt = GNT_I;
          end
        end
      end
      GNT_I: begin
        m_strobe = 1'b1;
        if (m_ready) begin
          i_ready   = 1'b1;
          state_nxt = DONE;
        end
      end
      GNT_D: begin
        m_strobe = 1'b1;
        if (m_ready) begin
          d_ready   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Both sides see memory data at all times; only ready is owner-qualified
  assign i_dout = m_dout;
  assign d_dout = m_dout;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - directed plus randomized bench with a transaction-level reference model
module tb_cache_mem_arbiter;

  localparam bit D_FIRST = 1'b1;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic [31:0] i_a = '0, d_a = '0, d_din = '0, m_dout = '0;
  logic        i_strobe = 1'b0, d_strobe = 1'b0, d_we = 1'b0, m_ready = 1'b0;
  logic [31:0] i_dout, d_dout, m_a, m_din;
  logic        i_ready, d_ready, m_we, m_strobe;

  int tests_run = 0;
  int tests_failed = 0;

  cache_mem_arbiter #(.A_WIDTH(32), .D_FIRST(D_FIRST)) dut (
    .clk(clk), .clrn(clrn),
    .i_a(i_a), .i_strobe(i_strobe), .i_dout(i_dout), .i_ready(i_ready),
    .d_a(d_a), .d_din(d_din), .d_we(d_we), .d_strobe(d_strobe),
    .d_dout(d_dout), .d_ready(d_ready),
    .m_a(m_a), .m_din(m_din), .m_we(m_we), .m_strobe(m_strobe),
    .m_dout(m_dout), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: owner 0 = bus free, 1 = instruction side, 2 = data side
  int          owner = 0;
  bit          turn = 1'b0;
  bit          last_d = ~D_FIRST;
  logic [31:0] exp_a = '0, exp_din = '0;
  logic        exp_we = 1'b0;
  int          i_pulses = 0, d_pulses = 0;
  bit          i_got = 1'b0, d_got = 1'b0;
  bit          pick_d;

  always @(negedge clk) begin
    if (!clrn) begin
      owner = 0; turn = 1'b0; last_d = ~D_FIRST; i_got = 1'b0; d_got = 1'b0;
      check_eq("rst_m_strobe", m_strobe, 1'b0);
      check_eq("rst_m_we", m_we, 1'b0);
      check_eq("rst_m_a", m_a, 32'd0);
      check_eq("rst_m_din", m_din, 32'd0);
      check_eq("rst_i_ready", i_ready, 1'b0);
      check_eq("rst_d_ready", d_ready, 1'b0);
    end else begin
      check_eq("m_strobe", m_strobe, owner != 0);
      if (owner != 0) begin
        check_eq("m_a", m_a, exp_a);
        check_eq("m_din", m_din, exp_din);
        check_eq("m_we", m_we, exp_we);
      end
      check_eq("i_ready", i_ready, owner == 1 && m_ready);
      check_eq("d_ready", d_ready, owner == 2 && m_ready);
      if (i_ready) begin check_eq("i_dout", i_dout, m_dout); i_pulses++; i_got = 1'b1; end
      if (d_ready) begin check_eq("d_dout", d_dout, m_dout); d_pulses++; d_got = 1'b1; end
      if (owner != 0) begin
        if (m_ready) begin owner = 0; turn = 1'b1; end
      end else if (turn) begin
        turn = 1'b0;
      end else if (i_strobe || d_strobe) begin
        if (i_strobe && d_strobe) begin pick_d = ~last_d; last_d = pick_d; end
        else pick_d = d_strobe;
        owner   = pick_d ? 2 : 1;
        exp_a   = pick_d ? d_a : i_a;
        exp_din = pick_d ? d_din : 32'd0;
        exp_we  = pick_d ? d_we : 1'b0;
      end
    end
  end

  // Memory responder: random or fixed latency, optional ready noise while idle
  int          mem_lat_fix = 2;
  int          lat = 0;
  bit          busy = 1'b0, spurious = 1'b0, force_mr = 1'b0, mem_fix_en = 1'b0;
  logic [31:0] mem_fix_data = '0;

  always @(posedge clk) begin
    #1;
    if (!clrn) begin
      busy = 1'b0; m_ready = 1'b0;
    end else if (m_strobe) begin
      if (!busy) begin
        busy = 1'b1;
        lat = (mem_lat_fix >= 0) ? mem_lat_fix : int'($urandom_range(0, 3));
      end
      if (lat == 0) begin
        m_ready = 1'b1; busy = 1'b0;
        m_dout = mem_fix_en ? mem_fix_data : $urandom;
      end else begin
        lat--; m_ready = 1'b0;
      end
    end else begin
      busy = 1'b0;
      m_ready = force_mr | (spurious && $urandom_range(0, 7) == 0);
      m_dout = $urandom;
    end
  end

  // Random requesters: hold strobe until ready, sometimes re-request or abandon early
  bit auto_mode = 1'b0;

  always @(posedge clk) begin
    #1;
    if (auto_mode) begin
      if (i_strobe) begin
        if (i_got) begin i_got = 1'b0; if ($urandom_range(0, 7) != 0) i_strobe = 1'b0; end
        else if ($urandom_range(0, 31) == 0) i_strobe = 1'b0;
      end else begin
        i_got = 1'b0; i_a = $urandom;
        if ($urandom_range(0, 2) == 0) i_strobe = 1'b1;
      end
      if (d_strobe) begin
        if (d_got) begin d_got = 1'b0; if ($urandom_range(0, 7) != 0) d_strobe = 1'b0; end
        else if ($urandom_range(0, 31) == 0) d_strobe = 1'b0;
        else if ($urandom_range(0, 3) == 0) d_din = $urandom;
      end else begin
        d_got = 1'b0; d_a = $urandom; d_din = $urandom; d_we = $urandom_range(0, 1) == 1;
        if ($urandom_range(0, 2) == 0) d_strobe = 1'b1;
      end
    end
  end

  task automatic wait_ready(output int side);
    side = 0;
    for (int k = 0; k < 40 && side == 0; k++) begin
      @(negedge clk);
      if (i_ready) side = 1;
      else if (d_ready) side = 2;
    end
  endtask

  int side, saved;

  initial begin
    repeat (3) @(posedge clk);
    #3 clrn = 1'b1;

    // Single instruction miss
    @(posedge clk); #1;
    mem_lat_fix = 3; mem_fix_en = 1'b1; mem_fix_data = 32'hDEAD_BEEF;
    i_a = 32'h0000_0100; i_strobe = 1'b1;
    @(posedge clk); @(negedge clk);
    check_eq("t1_m_strobe", m_strobe, 1'b1);
    check_eq("t1_m_a", m_a, 32'h100);
    check_eq("t1_m_we", m_we, 1'b0);
    wait_ready(side);
    check_eq("t1_side", side, 1);
    check_eq("t1_i_dout", i_dout, 32'hDEAD_BEEF);
    @(posedge clk); #1 i_strobe = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("t1_i_pulses", i_pulses, 1);
    check_eq("t1_d_pulses", d_pulses, 0);
    mem_fix_en = 1'b0;

    // Ties: data first after reset, then instruction on the next tie
    @(posedge clk); #1;
    i_a = 32'h0000_0200; d_a = 32'h0000_0300; d_din = 32'hA5A5_0001; d_we = 1'b0;
    i_strobe = 1'b1; d_strobe = 1'b1;
    wait_ready(side); check_eq("t2_first", side, 2);
    @(posedge clk); #1 d_strobe = 1'b0;
    wait_ready(side); check_eq("t2_second", side, 1);
    @(posedge clk); #1 i_strobe = 1'b0;
    @(posedge clk); #1 i_strobe = 1'b1; d_strobe = 1'b1;
    wait_ready(side); check_eq("t2_third", side, 1);
    @(posedge clk); #1 i_strobe = 1'b0;
    wait_ready(side); check_eq("t2_fourth", side, 2);
    @(posedge clk); #1 d_strobe = 1'b0;

    // Data write; write data changes mid-transaction must not reach memory
    @(posedge clk); #1;
    mem_lat_fix = 4; d_we = 1'b1; d_a = 32'h0000_2000; d_din = 32'h1234_5678; d_strobe = 1'b1;
    @(posedge clk); @(posedge clk); #1 d_din = 32'hFFFF_0000;
    @(negedge clk);
    check_eq("t3_m_din", m_din, 32'h1234_5678);
    check_eq("t3_m_we", m_we, 1'b1);
    check_eq("t3_m_a", m_a, 32'h2000);
    wait_ready(side); check_eq("t3_side", side, 2);
    @(posedge clk); #1 d_strobe = 1'b0; d_we = 1'b0;

    // Data request arriving while instruction transaction is busy
    @(posedge clk); #1;
    mem_lat_fix = 3; i_a = 32'h0000_0400; i_strobe = 1'b1;
    @(posedge clk); #1 d_a = 32'h0000_0500; d_din = 32'h0BAD_F00D; d_strobe = 1'b1;
    wait_ready(side); check_eq("t4_first", side, 1);
    @(posedge clk); #1 i_strobe = 1'b0;
    @(negedge clk); check_eq("t4_turnaround", m_strobe, 1'b0);
    wait_ready(side); check_eq("t4_second", side, 2);
    @(posedge clk); #1 d_strobe = 1'b0;

    // Instruction side abandons its request; transaction still completes
    @(posedge clk); #1;
    mem_lat_fix = 6; i_a = 32'h0000_0600; i_strobe = 1'b1;
    @(posedge clk); @(posedge clk); #1 i_strobe = 1'b0;
    wait_ready(side); check_eq("t5_side", side, 1);
    repeat (2) @(posedge clk);
    saved = i_pulses + d_pulses;
    #1 force_mr = 1'b1;
    repeat (3) @(posedge clk);
    #1 force_mr = 1'b0;
    @(negedge clk);
    check_eq("t5_idle_mready", i_pulses + d_pulses, saved);

    // Reset during a data grant
    @(posedge clk); #1;
    d_a = 32'h0000_0700; d_we = 1'b0; d_strobe = 1'b1;
    @(posedge clk); @(posedge clk);
    saved = d_pulses;
    #3 clrn = 1'b0;
    #1 check_eq("t6_m_strobe", m_strobe, 1'b0);
    check_eq("t6_d_ready", d_ready, 1'b0);
    d_strobe = 1'b0;
    @(posedge clk); #3 clrn = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("t6_no_pulse", d_pulses, saved);
    check_eq("t6_idle", m_strobe, 1'b0);

    // Randomized traffic
    @(posedge clk); #1;
    mem_lat_fix = -1; spurious = 1'b1; auto_mode = 1'b1;
    repeat (2000) @(posedge clk);
    #2 auto_mode = 1'b0; i_strobe = 1'b0; d_strobe = 1'b0;
    repeat (12) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single external memory port between the instruction-cache miss path and the data-cache miss/write-through path.
- Latches one request at a time and drives the memory port until the memory handshake completes.
- Routes the returned data and a one-cycle ready pulse back to the requester that owns the transaction.
- Sits between i_cache_simple / the data cache and the memory/bus bridge. Arbitration is round-robin on ties.

Parameters:
- A_WIDTH, 32, address width of requester and memory ports.
- D_FIRST, 1, winner of the first tie after reset (1 = data side, 0 = instruction side).

Ports:
- clk  in  1  clock; all state updates on posedge.
- clrn  in  1  asynchronous, active-low reset.
- i_a  in  A_WIDTH  instruction-side miss address.
- i_strobe  in  1  instruction-side read request; held high until i_ready.
- i_dout  out  32  read data to instruction side.
- i_ready  out  1  one-cycle completion pulse to instruction side.
- d_a  in  A_WIDTH  data-side address.
- d_din  in  32  data-side write data.
- d_we  in  1  data-side write enable (1 = write, 0 = read); sampled with d_strobe.
- d_strobe  in  1  data-side request; held high until d_ready.
- d_dout  out  32  read data to data side.
- d_ready  out  1  one-cycle completion pulse to data side.
- m_a  out  A_WIDTH  memory address (latched).
- m_din  out  32  memory write data (latched).
- m_we  out  1  memory write enable (latched).
- m_strobe  out  1  memory request, high for the whole transaction.
- m_dout  in  32  memory read data.
- m_ready  in  1  memory completion, valid while m_strobe is high.

Behaviour:
- Reset (clrn low, asynchronous):
  - State is IDLE.
  - m_strobe, m_we, i_ready and d_ready are 0.
  - m_a and m_din are 0.
  - last_grant is set so that the D_FIRST side wins the first tie.
- States are IDLE, GNT_I, GNT_D and DONE.
- IDLE:
  - m_strobe = 0.
  - If exactly one strobe is high, latch that side's address, write data (d_din/d_we for D; 0 and 0 for I) and owner, then go to that side's GNT state.
  - If both strobes are high, grant the side that is not last_grant, then update last_grant.
  - If neither strobe is high, stay in IDLE.
- GNT_I / GNT_D:
  - m_strobe = 1; m_a, m_din and m_we come from the latched registers and are stable for the whole transaction.
  - Requester inputs are ignored while in these states.
  - On the cycle m_ready = 1, assert the owner's ready combinationally. Owner dout is m_dout in that cycle. Next state is DONE.
- DONE:
  - One turnaround cycle: m_strobe = 0 and no ready is asserted.
  - This lets the requester drop its strobe before re-arbitration.
  - Always go to IDLE.
- Latency: the first request cycle sees m_strobe rise on the next edge. Ready follows m_ready with 0 cycles. The minimum round trip is 1 + memory latency + 1 turnaround.
- i_dout and d_dout are both wired to m_dout at all times. Only the ready pulses are qualified by owner.
- If a requester drops its strobe mid-transaction (for example an i-cache exception flush), the bus transaction still runs to completion and the ready pulse is still issued. No abort is allowed, because the memory side has no cancel.
- m_ready while in IDLE or DONE is ignored and produces no ready pulse.
- A non-owner strobe that arrives during a transaction waits; it is granted from IDLE after DONE.
- If a requester's strobe is still high when IDLE is re-entered after its own ready, it is treated as a new request. Requesters must drop their strobe the cycle after ready; a still-high strobe is a legal re-request.
- If reset asserts mid-transaction, m_strobe drops immediately, no ready is issued, and the state returns to IDLE.

Test Plan:
- Reset, then i_strobe = 1 with i_a = 0x0000_0100. Memory returns m_dout = 0xDEAD_BEEF after 3 cycles. Expect m_strobe high from cycle 1, m_a = 0x100, m_we = 0. i_ready pulses exactly once with i_dout = 0xDEAD_BEEF. d_ready stays 0.
- i_strobe and d_strobe both raised in the same cycle after reset (D_FIRST = 1). Expect the D transaction first, then the I transaction. On the next simultaneous tie, expect I first.
- Data write: d_we = 1, d_a = 0x2000, d_din = 0x1234_5678. Expect m_we = 1 and m_din = 0x1234_5678. Change d_din mid-transaction; m_din must stay 0x1234_5678.
- d_strobe raised while GNT_I is busy. Expect no m_a change until I completes, one DONE cycle with m_strobe = 0, then the D grant.
- i_strobe dropped two cycles into GNT_I. Expect m_strobe held until m_ready and an i_ready pulse still issued. m_ready forced high in IDLE produces no ready.
- clrn pulsed low during GNT_D. Expect m_strobe = 0 immediately, no d_ready, and IDLE after release.
